// File: rtl/seqdet_rr_sched.sv
// seqdet_rr_sched
//   One shared "01" sequence-detect engine (Moore, 3 states) time-multiplexed
//   over NCH serial bit channels. A round-robin arbiter grants at most one
//   channel per cycle. The engine advances that channel's stored state
//   context and reports a detection tagged with the channel index.
//
// Handshake: a bit on channel i transfers on a rising clk edge when
//   bit_valid[i] & bit_ready[i]. bit_ready is the arbiter grant. It is
//   combinational and depends on bit_valid (ready-after-valid), so a
//   producer raises valid without waiting for ready. A producer holds
//   valid/data until the bit is taken.
//
// Ports:
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous reset, active-high
//   en         in   1      global enable; 0 -> no grants
//   bit_valid  in   NCH    per-channel bit offer
//   bit_in     in   NCH    per-channel serial data bit
//   bit_ready  out  NCH    per-channel grant (one-hot or zero)
//   ch_clr     in   NCH    per-channel synchronous context clear
//   det_vld    out  1      registered one-cycle detection pulse
//   det_ch     out  CHW    channel of the detection (holds between pulses)
//   busy       out  1      registered; some context is in S1 or S2
//   cnt_sel    in   CHW    hit-counter select   (SEQDET_HITCNT_EN only)
//   cnt_data   out  8      selected hit counter (SEQDET_HITCNT_EN only)
//   dbg_ctx    out  2*NCH  debug: all channel contexts, channel i at [2i+1:2i]
//
// Optional build macro: SEQDET_HITCNT_EN adds per-channel 8-bit saturating
//   hit counters with the cnt_sel/cnt_data read port.

module seqdet_rr_sched #(
  parameter int NCH = 4,
  parameter int CHW = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [NCH-1:0]   bit_valid,
  input  logic [NCH-1:0]   bit_in,
  output logic [NCH-1:0]   bit_ready,
  input  logic [NCH-1:0]   ch_clr,
  output logic             det_vld,
  output logic [CHW-1:0]   det_ch,
  output logic             busy,
`ifdef SEQDET_HITCNT_EN
  input  logic [CHW-1:0]   cnt_sel,
  output logic [7:0]       cnt_data,
`endif
  output logic [2*NCH-1:0] dbg_ctx
);

  localparam logic [1:0] S0 = 2'd1;
  localparam logic [1:0] S1 = 2'd2;
  localparam logic [1:0] S2 = 2'd3;

  logic [1:0]     r_ctx   [NCH];
  logic [1:0]     w_ctx_n [NCH];
  logic [CHW-1:0] r_ptr;
  logic [NCH-1:0] w_elig;
  logic [NCH-1:0] w_grant;
  logic [NCH-1:0] w_hit;
  logic [CHW-1:0] w_gidx;
  logic           w_found;
  logic           w_busy_n;

  // (a + k) mod NCH for 0 <= k < NCH; NCH need not be a power of two.
  function automatic logic [CHW-1:0] wrap_add(input logic [CHW-1:0] a, input int k);
    int s;
    s = int'(a) + k;
    if (s >= NCH) s = s - NCH;
    return CHW'(s);
  endfunction

  // Moore "01" detector step. The illegal code 2'd0 behaves as S0.
  function automatic logic [1:0] fsm_next(input logic [1:0] cur, input logic x);
    case (cur)
      S1:      return x ? S2 : S1;
      S2:      return x ? S0 : S1;
      default: return x ? S0 : S1;
    endcase
  endfunction

  // A channel being cleared is never granted; its bit stays offered.
  assign w_elig = (en && !rst) ? (bit_valid & ~ch_clr) : '0;

  // Round-robin search starting at r_ptr; first eligible channel wins.
  always_comb begin
    w_grant = '0;
    w_gidx  = '0;
    w_found = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (!w_found && w_elig[wrap_add(r_ptr, k)]) begin
        w_found                    = 1'b1;
        w_gidx                     = wrap_add(r_ptr, k);
        w_grant[wrap_add(r_ptr, k)] = 1'b1;
      end
    end
  end

  assign bit_ready = w_grant;

  // Next contexts: clear beats everything, grant steps the FSM, else hold.
  always_comb begin
    w_busy_n = 1'b0;
    w_hit    = '0;
    for (int i = 0; i < NCH; i++) begin
      if (ch_clr[i]) begin
        w_ctx_n[i] = S0;
      end else if (w_grant[i]) begin
        w_ctx_n[i] = fsm_next(r_ctx[i], bit_in[i]);
      end else begin
        w_ctx_n[i] = (r_ctx[i] == 2'd0) ? S0 : r_ctx[i];
      end
      w_hit[i] = w_grant[i] && (w_ctx_n[i] == S2);
      if (w_ctx_n[i] == S1 || w_ctx_n[i] == S2) w_busy_n = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) r_ctx[i] <= S0;
      r_ptr   <= '0;
      det_vld <= 1'b0;
      det_ch  <= '0;
      busy    <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) r_ctx[i] <= w_ctx_n[i];
      if (w_found) r_ptr <= wrap_add(w_gidx, 1);
      det_vld <= |w_hit;
      if (|w_hit) det_ch <= w_gidx;
      busy    <= w_busy_n;
    end
  end

  always_comb begin
    dbg_ctx = '0;
    for (int i = 0; i < NCH; i++) dbg_ctx[2*i +: 2] = r_ctx[i];
  end

`ifdef SEQDET_HITCNT_EN
  logic [7:0] r_cnt [NCH];

  // Clear wins over a coinciding increment; counters stick at 8'hFF.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (ch_clr[i]) r_cnt[i] <= '0;
        else if (w_hit[i] && r_cnt[i] != 8'hFF) r_cnt[i] <= r_cnt[i] + 8'd1;
      end
    end
  end

  assign cnt_data = r_cnt[cnt_sel];
`endif

endmodule

// File: tb/tb_seqdet_rr_sched.sv
// Directed bench for seqdet_rr_sched (NCH=4). Inputs change 1 time unit
// after a rising edge; combinational bit_ready is checked before the next
// edge, registered outputs 1 time unit after it.

module tb_seqdet_rr_sched;

  localparam int NCH = 4;
  localparam int CHW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           en;
  logic [NCH-1:0] bit_valid;
  logic [NCH-1:0] bit_in;
  logic [NCH-1:0] bit_ready;
  logic [NCH-1:0] ch_clr;
  logic           det_vld;
  logic [CHW-1:0] det_ch;
  logic           busy;
  logic [2*NCH-1:0] dbg_ctx;
`ifdef SEQDET_HITCNT_EN
  logic [CHW-1:0] cnt_sel;
  logic [7:0]     cnt_data;
`endif

  int n_vec = 0;
  int n_err = 0;

  seqdet_rr_sched #(.NCH(NCH)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .bit_valid (bit_valid),
    .bit_in    (bit_in),
    .bit_ready (bit_ready),
    .ch_clr    (ch_clr),
    .det_vld   (det_vld),
    .det_ch    (det_ch),
    .busy      (busy),
`ifdef SEQDET_HITCNT_EN
    .cnt_sel   (cnt_sel),
    .cnt_data  (cnt_data),
`endif
    .dbg_ctx   (dbg_ctx)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs, check grant, clock, check registered outputs.
  task automatic xfer(input string tag, input logic [3:0] v, input logic [3:0] b,
                      input logic [3:0] clr, input logic [3:0] exp_rdy,
                      input logic exp_det, input logic [1:0] exp_ch, input logic exp_busy);
    bit_valid = v;
    bit_in    = b;
    ch_clr    = clr;
    #1;
    chk({tag, ".ready"}, 32'(bit_ready), 32'(exp_rdy));
    @(posedge clk); #1;
    chk({tag, ".det_vld"}, 32'(det_vld), 32'(exp_det));
    if (exp_det) chk({tag, ".det_ch"}, 32'(det_ch), 32'(exp_ch));
    chk({tag, ".busy"}, 32'(busy), 32'(exp_busy));
  endtask

  // Asynchronous reset pulse starting mid-cycle; checks outputs at once.
  task automatic pulse_rst(input string tag);
    bit_valid = 4'b1111;
    ch_clr    = 4'b0000;
    #2;
    rst = 1'b1;
    #1;
    chk({tag, ".ready"},   32'(bit_ready), 32'h0);
    chk({tag, ".det_vld"}, 32'(det_vld),   32'h0);
    chk({tag, ".det_ch"},  32'(det_ch),    32'h0);
    chk({tag, ".busy"},    32'(busy),      32'h0);
    chk({tag, ".ctx"},     32'(dbg_ctx),   32'h55);
    @(posedge clk); #1;
    bit_valid = 4'b0000;
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; bit_valid = '0; bit_in = '0; ch_clr = '0;
`ifdef SEQDET_HITCNT_EN
    cnt_sel = '0;
`endif
    // reset state
    @(posedge clk); #1;
    bit_valid = 4'b1111; en = 1'b1;
    #1;
    chk("rst.ready",   32'(bit_ready), 32'h0);
    chk("rst.det_vld", 32'(det_vld),   32'h0);
    chk("rst.det_ch",  32'(det_ch),    32'h0);
    chk("rst.busy",    32'(busy),      32'h0);
    chk("rst.ctx",     32'(dbg_ctx),   32'h55);
    @(posedge clk); #1;
    bit_valid = '0; rst = 1'b0;

    // single channel, bits 1,0,1,1,0,1 -> det after 3rd and 6th
    xfer("sc1", 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b0, 2'd0, 1'b0);
    xfer("sc2", 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b0, 2'd0, 1'b1);
    xfer("sc3", 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b1, 2'd0, 1'b1);
    xfer("sc4", 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b0, 2'd0, 1'b0);
    xfer("sc5", 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b0, 2'd0, 1'b1);
    xfer("sc6", 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b1, 2'd0, 1'b1);
    xfer("sc_idle", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b1);

    // ch0 to S1, then async reset mid-cycle, then bit 1 gives no det
    xfer("ar_pre", 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b0, 2'd0, 1'b1);
    pulse_rst("ar");
    xfer("ar_post", 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b0, 2'd0, 1'b0);

    // fairness from ptr=0, all valid; ch2 gets 0 then 1
    pulse_rst("fr_rst");
    xfer("fr1", 4'b1111, 4'b1011, 4'b0000, 4'b0001, 1'b0, 2'd0, 1'b0);
    xfer("fr2", 4'b1111, 4'b1011, 4'b0000, 4'b0010, 1'b0, 2'd0, 1'b0);
    xfer("fr3", 4'b1111, 4'b1011, 4'b0000, 4'b0100, 1'b0, 2'd0, 1'b1);
    xfer("fr4", 4'b1111, 4'b1011, 4'b0000, 4'b1000, 1'b0, 2'd0, 1'b1);
    xfer("fr5", 4'b1111, 4'b1111, 4'b0000, 4'b0001, 1'b0, 2'd0, 1'b1);
    xfer("fr6", 4'b1111, 4'b1111, 4'b0000, 4'b0010, 1'b0, 2'd0, 1'b1);
    xfer("fr7", 4'b1111, 4'b1111, 4'b0000, 4'b0100, 1'b1, 2'd2, 1'b1);
    xfer("fr8", 4'b1111, 4'b1111, 4'b0000, 4'b1000, 1'b0, 2'd0, 1'b1);

    // interleaved contexts (clear ch2 first so busy reflects ch1/ch3 only)
    xfer("il_clr", 4'b0000, 4'b0000, 4'b0100, 4'b0000, 1'b0, 2'd0, 1'b0);
    xfer("il1", 4'b0010, 4'b0000, 4'b0000, 4'b0010, 1'b0, 2'd0, 1'b1);
    xfer("il3", 4'b1000, 4'b0000, 4'b0000, 4'b1000, 1'b0, 2'd0, 1'b1);
    xfer("il1b", 4'b0010, 4'b0010, 4'b0000, 4'b0010, 1'b1, 2'd1, 1'b1);
    chk("il.ctx", 32'(dbg_ctx), 32'h9D);

    // ch_clr collision on ch0 in S1
    xfer("cc_s1", 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b0, 2'd0, 1'b1);
    xfer("cc_col", 4'b0001, 4'b0001, 4'b0001, 4'b0000, 1'b0, 2'd0, 1'b1);
    xfer("cc_after", 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b0, 2'd0, 1'b1);
    // clearing another channel leaves the current grant alone
    xfer("cc_other", 4'b0001, 4'b0001, 4'b0010, 4'b0001, 1'b0, 2'd0, 1'b1);
    chk("cc.ctx", 32'(dbg_ctx), 32'h95);

    // en=0 for 5 cycles: no grants, contexts hold
    en = 1'b0;
    for (int c = 0; c < 5; c++)
      xfer("en_off", 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b1);
    chk("en_off.ctx", 32'(dbg_ctx), 32'h95);
    en = 1'b1;
    // ch3 history kept across the disabled window
    xfer("en_on", 4'b1000, 4'b1000, 4'b0000, 4'b1000, 1'b1, 2'd3, 1'b1);

`ifdef SEQDET_HITCNT_EN
    // 300 detections on ch1 saturate its counter; clear empties it
    for (int n = 0; n < 300; n++) begin
      bit_valid = 4'b0010; ch_clr = 4'b0000;
      bit_in = 4'b0000;
      @(posedge clk); #1;
      bit_in = 4'b0010;
      @(posedge clk); #1;
    end
    bit_valid = 4'b0000;
    cnt_sel = 2'd1;
    #1;
    chk("cnt.sat", 32'(cnt_data), 32'hFF);
    xfer("cnt_clr", 4'b0000, 4'b0000, 4'b0010, 4'b0000, 1'b0, 2'd0, 1'b1);
    chk("cnt.clr", 32'(cnt_data), 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seqdet_rr_sched.md
Name: seqdet_rr_sched

Overview:
- Shares one "01" sequence-detect engine (Moore, 3-state) among NCH serial bit channels.
- Each channel offers bits over a valid/ready handshake. A round-robin arbiter grants at most one channel per cycle.
- The engine advances that channel's stored state context and reports detections tagged with the channel index.
- Sits between the serial front-ends and the event/interrupt logic.

Parameters:
- NCH, 4, number of requesting channels, legal range 2..16.
- CHW, $clog2(NCH), width of channel index (derived; not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  global enable; when 0, no grants are issued.
- bit_valid  in  NCH  per-channel request; bit i offers bit_in[i].
- bit_in  in  NCH  per-channel serial data bit.
- bit_ready  out  NCH  per-channel grant, one-hot or zero, combinational.
- ch_clr  in  NCH  per-channel synchronous context clear.
- det_vld  out  1  registered pulse: a "01" was completed on det_ch.
- det_ch  out  CHW  channel index of the detection.
- busy  out  1  registered; 1 if any channel context is in S1 or S2.

Behaviour:
- Context: per channel, a 2-bit state. Encoding S0=2'd1, S1=2'd2, S2=2'd3. Value 2'd0 is illegal and treated as S0.
- Transitions, applied only on a transfer (bit_valid[i] & bit_ready[i]):
  - S0: x=1 -> S0, x=0 -> S1.
  - S1: x=1 -> S2, x=0 -> S1.
  - S2: x=1 -> S0, x=0 -> S1.
- Non-granted channels hold their context.
- Arbitration:
  - Round-robin pointer ptr (CHW bits, reset 0).
  - Grant goes to the first i with bit_valid[i] & ~ch_clr[i], searching ptr, ptr+1, ... mod NCH.
  - On a grant, ptr <= granted index + 1 mod NCH. With no grant, ptr holds.
- bit_ready = grant vector. It is 0 when en=0 or rst=1. Ready depends on valid (ready-after-valid); producers must not wait for ready before asserting valid.
- Detection:
  - det_vld=1 for exactly one cycle, the cycle after a transfer whose next state is S2.
  - det_ch = granted index, registered with det_vld. det_ch holds its last value when det_vld=0.
  - Latency from accepted bit to det_vld: 1 cycle.
- ch_clr[i]:
  - Context i <= S0 on the next edge.
  - Channel i is not granted in the same cycle; its bit stays offered and is taken later.
  - Clears of other channels do not affect the current grant.
- en deasserted mid-stream: contexts and ptr hold; no detections are lost or created.
- busy is registered from the next-state contexts.
- Reset, asynchronous:
  - All contexts S0, ptr=0, det_vld=0, det_ch=0, busy=0.
  - bit_ready is forced 0 while rst=1.
  - Reset mid-sequence discards partial "0" history.
- Single channel, continuous valid: accepted every cycle, since it is the only requester. Overlapping detections follow the state table; "0101" gives two det pulses.
- All NCH channels continuously valid: each is granted once every NCH cycles, in order, with no starvation.

Optional Feature:
- Macro: SEQDET_HITCNT_EN.
- Defined:
  - Adds per-channel 8-bit saturating hit counters, incremented on each detection of that channel. They saturate at 8'hFF and are cleared by ch_clr[i] or rst.
  - Adds ports cnt_sel (in, CHW) and cnt_data (out, 8). cnt_data is combinational from the selected counter.
  - When the increment and the clear of the same channel coincide, the clear wins.
- Not defined: no counters and no cnt_sel/cnt_data ports. All other behaviour is identical.

Test Plan:
- Reset then single channel: NCH=4, en=1, ch0 valid with bits 1,0,1,1,0,1 on consecutive grants -> det_vld pulses exactly twice, one cycle after the 3rd and 6th accepted bits, det_ch=0 both times.
- Fairness: all 4 channels valid continuously from ptr=0 -> grants cycle 0,1,2,3,0,...; each bit_ready is high 1 cycle in 4. Channel 2 fed 0,1 on its grants -> det_ch=2.
- Interleaved contexts: ch1 sends 0, ch3 sends 0, then ch1 sends 1 -> det on ch1 only; ch3 stays S1 and busy=1.
- ch_clr collision: ch0 in S1 and valid with bit 1 while ch_clr[0]=1 -> no grant to ch0 that cycle, ch0 context becomes S0, next grant of bit 1 gives no det.
- en and reset: en=0 for 5 cycles with all valid -> bit_ready=0 and contexts unchanged. Async rst pulse mid-cycle with ch0 in S1 -> outputs 0 immediately; afterwards bit 1 on ch0 gives no det.
- SEQDET_HITCNT_EN: 300 detections on ch1 -> cnt_sel=1 reads 8'hFF; ch_clr[1] -> reads 0.
